reg_writeback_arb: RTL and testbench

- Write-side front end for the 32x32 CPU register file.
- Merges write-back requests from two producers into the register file's single write port (wr_en / wr_reg / wr_dat):
  - A: single-cycle ALU path, fixed priority, no backpressure.
  - B: long-latency path (load / mult-div), buffered in a small FIFO with a valid/ready handshake.
- Includes a starvation guard so B always drains, and an optional forwarding lookup over pending writes.

---
 rtl/reg_writeback_arb.sv | 149 ++++++++++++++
 tb/tb_reg_writeback_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_arb.sv
// reg_writeback_arb: merges the single-cycle ALU write-back path (A) and the
// buffered long-latency path (B) onto the register file's one write port.
// A has fixed priority; a starvation guard forces a B pop after STARVE_MAX
// consecutive A wins against a non-empty FIFO.
// Optional forwarding lookup over pending writes: define WB_ARB_FWD_EN.
module reg_writeback_arb #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned AW         = 5,
    parameter int unsigned DW         = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    input  logic [AW-1:0]              a_reg,
    input  logic [DW-1:0]              a_dat,
    output logic                       a_hold,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [AW-1:0]              b_reg,
    input  logic [DW-1:0]              b_dat,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_reg,
    output logic [DW-1:0]              wr_dat,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
    input  logic [AW-1:0]              q_reg,
    output logic                       q_hit,
    output logic [DW-1:0]              q_dat
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0] mem_reg_q [DEPTH];
    logic [DW-1:0] mem_dat_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] starve_q, starve_d;
    logic          a_hold_q, a_hold_d;
    logic          wr_en_q;
    logic [AW-1:0] wr_reg_q;
    logic [DW-1:0] wr_dat_q;

    logic fifo_empty, fifo_full, a_eff, push, pop;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign b_ready    = !rst && !fifo_full;
    assign a_eff      = a_valid && !a_hold_q && (a_reg != '0);
    // Writes to r0 are accepted on the handshake but never stored.
    assign push       = b_valid && b_ready && (b_reg != '0);
    assign pop        = !a_eff && !fifo_empty;

    assign a_hold   = a_hold_q;
    assign wr_en    = wr_en_q;
    assign wr_reg   = wr_reg_q;
    assign wr_dat   = wr_dat_q;
    assign fifo_cnt = cnt_q;

    // Starvation count and the one-cycle hold it triggers on reaching the limit.
    always_comb begin
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (a_eff) begin
            starve_d = starve_q + 1'b1;
        end
        a_hold_d = (starve_d == SW'(STARVE_MAX));
    end

    // FIFO storage; data only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg_q[wr_ptr_q] <= b_reg;
            mem_dat_q[wr_ptr_q] <= b_dat;
        end
    end

    // FIFO pointers/occupancy, starvation state and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            a_hold_q <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_reg_q <= '0;
            wr_dat_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            starve_q <= starve_d;
            a_hold_q <= a_hold_d;
            if (a_eff) begin
                wr_en_q  <= 1'b1;
                wr_reg_q <= a_reg;
                wr_dat_q <= a_dat;
            end else if (!fifo_empty) begin
                wr_en_q  <= 1'b1;
                wr_reg_q <= mem_reg_q[rd_ptr_q];
                wr_dat_q <= mem_dat_q[rd_ptr_q];
            end else begin
                wr_en_q  <= 1'b0;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    logic [PW-1:0] idx;

    // Forwarding lookup: output register first, then FIFO oldest-to-youngest,
    // so later matches override and the youngest pending write wins.
    always_comb begin
        q_hit = 1'b0;
        q_dat = '0;
        idx   = '0;
        if (q_reg != '0) begin
            if (wr_en_q && (wr_reg_q == q_reg)) begin
                q_hit = 1'b1;
                q_dat = wr_dat_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < cnt_q) && (mem_reg_q[idx] == q_reg)) begin
                    q_hit = 1'b1;
                    q_dat = mem_dat_q[idx];
                end
            end
        end
    end
`else
    logic unused_q_reg;
    assign unused_q_reg = ^q_reg;
    assign q_hit        = 1'b0;
    assign q_dat        = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Directed self-checking bench for reg_writeback_arb (DEPTH=4, STARVE_MAX=8).
module tb_reg_writeback_arb;

    logic        clk, rst;
    logic        a_valid, a_hold;
    logic [4:0]  a_reg;
    logic [31:0] a_dat;
    logic        b_valid, b_ready;
    logic [4:0]  b_reg;
    logic [31:0] b_dat;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_dat;
    logic [2:0]  fifo_cnt;
    logic [4:0]  q_reg;
    logic        q_hit;
    logic [31:0] q_dat;

    int total = 0;
    int bad   = 0;

`ifdef WB_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    reg_writeback_arb #(.DEPTH(4), .STARVE_MAX(8), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_dat(a_dat), .a_hold(a_hold),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_dat(b_dat),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_dat(wr_dat), .fifo_cnt(fifo_cnt),
        .q_reg(q_reg), .q_hit(q_hit), .q_dat(q_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b0; a_reg = '0; a_dat = '0;
        b_valid = 1'b0; b_reg = '0; b_dat = '0; q_reg = '0;
        tick(); tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
        total++; if (wr_reg !== 5'd0) begin bad++; $display("FAIL rst_wr_reg: got %0d want 0", wr_reg); end
        total++; if (wr_dat !== 32'h0) begin bad++; $display("FAIL rst_wr_dat: got %0h want 0", wr_dat); end
        total++; if (a_hold !== 1'b0) begin bad++; $display("FAIL rst_a_hold: got %0b want 0", a_hold); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL rst_b_ready: got %0b want 0", b_ready); end
        rst = 1'b0;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rel_b_ready: got %0b want 1", b_ready); end
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL rst_q_hit: got %0b want 0", q_hit); end
    endtask

    task automatic test_a_path();
        a_valid = 1'b1; a_reg = 5'd3; a_dat = 32'h11111111;
        tick();
        a_valid = 1'b0;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL a_wr_en: got %0b want 1", wr_en); end
        total++; if (wr_reg !== 5'd3) begin bad++; $display("FAIL a_wr_reg: got %0d want 3", wr_reg); end
        total++; if (wr_dat !== 32'h11111111) begin bad++; $display("FAIL a_wr_dat: got %0h want 11111111", wr_dat); end
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL a_idle_en: got %0b want 0", wr_en); end
        total++; if (wr_reg !== 5'd3) begin bad++; $display("FAIL a_hold_reg: got %0d want 3", wr_reg); end
        total++; if (wr_dat !== 32'h11111111) begin bad++; $display("FAIL a_hold_dat: got %0h want 11111111", wr_dat); end
    endtask

    task automatic test_b_path();
        b_valid = 1'b1; b_reg = 5'd5; b_dat = 32'hA5;
        tick();
        b_reg = 5'd6; b_dat = 32'hB6;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL b_lat_en: got %0b want 0", wr_en); end
        total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL b_cnt1: got %0d want 1", fifo_cnt); end
        tick();
        b_valid = 1'b0;
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL b_first_en: got %0b want 1", wr_en); end
        total++; if (wr_reg !== 5'd5) begin bad++; $display("FAIL b_first_reg: got %0d want 5", wr_reg); end
        total++; if (wr_dat !== 32'hA5) begin bad++; $display("FAIL b_first_dat: got %0h want a5", wr_dat); end
        total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL b_pushpop_cnt: got %0d want 1", fifo_cnt); end
        tick();
        total++; if (wr_reg !== 5'd6) begin bad++; $display("FAIL b_second_reg: got %0d want 6", wr_reg); end
        total++; if (wr_dat !== 32'hB6) begin bad++; $display("FAIL b_second_dat: got %0h want b6", wr_dat); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL b_drain_cnt: got %0d want 0", fifo_cnt); end
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL b_idle_en: got %0b want 0", wr_en); end
    endtask

    task automatic test_full();
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_reg = 5'(i + 1); a_dat = 32'hA000 + 32'(i);
            b_reg = 5'(10 + i); b_dat = 32'h100 + 32'(i);
            tick();
            total++; if (wr_reg !== 5'(i + 1)) begin bad++; $display("FAIL full_a_reg%0d: got %0d want %0d", i, wr_reg, i + 1); end
            total++; if (fifo_cnt !== 3'(i + 1)) begin bad++; $display("FAIL full_cnt%0d: got %0d want %0d", i, fifo_cnt, i + 1); end
        end
        a_reg = 5'd5; a_dat = 32'hA004; b_reg = 5'd14; b_dat = 32'h104;
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL full_b_ready: got %0b want 0", b_ready); end
        tick();
        total++; if (fifo_cnt !== 3'd4) begin bad++; $display("FAIL full_held_cnt: got %0d want 4", fifo_cnt); end
        total++; if (wr_reg !== 5'd5) begin bad++; $display("FAIL full_a5: got %0d want 5", wr_reg); end
        a_valid = 1'b0;
        tick();
        total++; if (wr_reg !== 5'd10) begin bad++; $display("FAIL full_pop10: got %0d want 10", wr_reg); end
        total++; if (wr_dat !== 32'h100) begin bad++; $display("FAIL full_pop10_dat: got %0h want 100", wr_dat); end
        total++; if (fifo_cnt !== 3'd3) begin bad++; $display("FAIL full_refuse_cnt: got %0d want 3", fifo_cnt); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL full_ready_again: got %0b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        total++; if (wr_reg !== 5'd11) begin bad++; $display("FAIL full_pop11: got %0d want 11", wr_reg); end
        total++; if (fifo_cnt !== 3'd3) begin bad++; $display("FAIL full_accept5_cnt: got %0d want 3", fifo_cnt); end
        for (int j = 12; j <= 14; j++) begin
            tick();
            total++; if (wr_reg !== 5'(j)) begin bad++; $display("FAIL drain_reg%0d: got %0d want %0d", j, wr_reg, j); end
            total++; if (wr_dat !== 32'h100 + 32'(j - 10)) begin bad++; $display("FAIL drain_dat%0d: got %0h want %0h", j, wr_dat, 32'h100 + 32'(j - 10)); end
        end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL full_end_cnt: got %0d want 0", fifo_cnt); end
        tick();
    endtask

    task automatic test_starve();
        logic exp_hold;
        a_valid = 1'b1; a_reg = 5'd30; a_dat = 32'h3030;
        b_valid = 1'b1; b_reg = 5'd20; b_dat = 32'h2020;
        tick();
        b_valid = 1'b0;
        total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL st_cnt: got %0d want 1", fifo_cnt); end
        for (int k = 1; k <= 8; k++) begin
            a_reg = 5'(k); a_dat = 32'hC00 + 32'(k);
            tick();
            exp_hold = (k == 8);
            total++; if (wr_reg !== 5'(k)) begin bad++; $display("FAIL st_a_reg%0d: got %0d want %0d", k, wr_reg, k); end
            total++; if (a_hold !== exp_hold) begin bad++; $display("FAIL st_hold%0d: got %0b want %0b", k, a_hold, exp_hold); end
        end
        a_reg = 5'd9; a_dat = 32'hC09;
        tick();
        total++; if (wr_reg !== 5'd20) begin bad++; $display("FAIL st_b_reg: got %0d want 20", wr_reg); end
        total++; if (wr_dat !== 32'h2020) begin bad++; $display("FAIL st_b_dat: got %0h want 2020", wr_dat); end
        total++; if (a_hold !== 1'b0) begin bad++; $display("FAIL st_hold_drop: got %0b want 0", a_hold); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL st_cnt0: got %0d want 0", fifo_cnt); end
        tick();
        total++; if (wr_reg !== 5'd9) begin bad++; $display("FAIL st_resume_reg: got %0d want 9", wr_reg); end
        total++; if (wr_dat !== 32'hC09) begin bad++; $display("FAIL st_resume_dat: got %0h want c09", wr_dat); end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_reg_zero();
        a_valid = 1'b1; a_reg = 5'd1; a_dat = 32'h1;
        b_valid = 1'b1; b_reg = 5'd7; b_dat = 32'h77;
        tick();
        a_reg = 5'd0; a_dat = 32'hBAD; b_reg = 5'd0; b_dat = 32'hDEAD;
        total++; if (fifo_cnt !== 3'd1) begin bad++; $display("FAIL z_cnt1: got %0d want 1", fifo_cnt); end
        tick();
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL z_b_en: got %0b want 1", wr_en); end
        total++; if (wr_reg !== 5'd7) begin bad++; $display("FAIL z_b_reg: got %0d want 7", wr_reg); end
        total++; if (wr_dat !== 32'h77) begin bad++; $display("FAIL z_b_dat: got %0h want 77", wr_dat); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL z_discard_cnt: got %0d want 0", fifo_cnt); end
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL z_no_r0_write: got %0b want 0", wr_en); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL z_cnt_still0: got %0d want 0", fifo_cnt); end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
    endtask

    task automatic test_fwd_and_reset();
        logic        exp_hit;
        logic [31:0] exp_dat;
        a_valid = 1'b1; a_reg = 5'd1; a_dat = 32'h51;
        b_valid = 1'b1; b_reg = 5'd9; b_dat = 32'h1;
        tick();
        a_reg = 5'd2; a_dat = 32'h52; b_dat = 32'h2;
        tick();
        b_valid = 1'b0; a_reg = 5'd3; a_dat = 32'h53;
        tick();
        total++; if (fifo_cnt !== 3'd2) begin bad++; $display("FAIL f_cnt2: got %0d want 2", fifo_cnt); end
        q_reg = 5'd9; #1;
        exp_hit = FWD; exp_dat = FWD ? 32'h2 : 32'h0;
        total++; if (q_hit !== exp_hit) begin bad++; $display("FAIL f_hit9: got %0b want %0b", q_hit, exp_hit); end
        total++; if (q_dat !== exp_dat) begin bad++; $display("FAIL f_dat9: got %0h want %0h", q_dat, exp_dat); end
        q_reg = 5'd3; #1;
        exp_dat = FWD ? 32'h53 : 32'h0;
        total++; if (q_hit !== exp_hit) begin bad++; $display("FAIL f_hit_out: got %0b want %0b", q_hit, exp_hit); end
        total++; if (q_dat !== exp_dat) begin bad++; $display("FAIL f_dat_out: got %0h want %0h", q_dat, exp_dat); end
        q_reg = 5'd0; #1;
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL f_hit_r0: got %0b want 0", q_hit); end
        q_reg = 5'd4; #1;
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL f_hit_miss: got %0b want 0", q_hit); end
        a_valid = 1'b0; q_reg = 5'd9;
        tick();
        total++; if (wr_reg !== 5'd9) begin bad++; $display("FAIL f_pop_reg: got %0d want 9", wr_reg); end
        total++; if (wr_dat !== 32'h1) begin bad++; $display("FAIL f_pop_dat: got %0h want 1", wr_dat); end
        exp_dat = FWD ? 32'h2 : 32'h0;
        total++; if (q_dat !== exp_dat) begin bad++; $display("FAIL f_dat_drain: got %0h want %0h", q_dat, exp_dat); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mr_wr_en: got %0b want 0", wr_en); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL mr_cnt: got %0d want 0", fifo_cnt); end
        total++; if (q_hit !== 1'b0) begin bad++; $display("FAIL mr_q_hit: got %0b want 0", q_hit); end
        total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL mr_b_ready: got %0b want 0", b_ready); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mr_lost_entries: got %0b want 0", wr_en); end
        total++; if (fifo_cnt !== 3'd0) begin bad++; $display("FAIL mr_cnt_after: got %0d want 0", fifo_cnt); end
    endtask

    initial begin
        test_reset();
        test_a_path();
        test_b_path();
        test_full();
        test_starve();
        test_reg_zero();
        test_fwd_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
